// File: rtl/frame_buf_stream.sv
// frame_buf_stream: W x H pixel frame buffer with a random write/read port and a
// valid/ready streaming readout carrying row (m_eol) and frame (m_last) markers.
// Define FRAME_BUF_CLEAR_EN to add the clr port and a CLEAR state that zeroes the memory.
module frame_buf_stream #(
  parameter int W               = 64,
  parameter int H               = 64,
  parameter int DATA_W          = 8,
  parameter int TOTAL_PIXEL     = W*H,
  parameter int TOTAL_PIXEL_BIT = $clog2(W*H)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [TOTAL_PIXEL_BIT-1:0] wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [TOTAL_PIXEL_BIT-1:0] rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  input  logic                       start,
`ifdef FRAME_BUF_CLEAR_EN
  input  logic                       clr,
`endif
  output logic                       busy,
  output logic                       done,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic                       m_eol,
  output logic                       m_last
);

  localparam int PTR_W = TOTAL_PIXEL_BIT + 1;
  localparam int COL_W = (W > 1) ? $clog2(W) : 1;

`ifdef FRAME_BUF_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CLEAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN} state_t;
`endif

  logic [DATA_W-1:0] mem [TOTAL_PIXEL];

  state_t                     state_q;
  logic [PTR_W-1:0]           ptr_q;
  logic [TOTAL_PIXEL_BIT-1:0] beat_q;
  logic [COL_W-1:0]           col_q;
  logic                       busy_q;
  logic                       done_q;
  logic [DATA_W-1:0]          rd_data_q;
  logic                       rd_vld_p1;
  logic [DATA_W-1:0]          pix_p1;
  logic                       hd_vld_q;
  logic [DATA_W-1:0]          hd_data_q;
  logic                       sk_vld_q;
  logic [DATA_W-1:0]          sk_data_q;

  logic                       pop, push, issue, last_beat;
  logic [1:0]                 occ;
  logic [TOTAL_PIXEL_BIT-1:0] raddr;
  logic [DATA_W-1:0]          mem_rdata;
  logic                       we;
  logic [TOTAL_PIXEL_BIT-1:0] waddr;
  logic [DATA_W-1:0]          wdata;

  // Credit accounting covers the head, skid and the read in flight so the buffer never overflows.
  assign pop       = hd_vld_q & m_ready;
  assign push      = rd_vld_p1;
  assign occ       = {1'b0, hd_vld_q} + {1'b0, sk_vld_q} + {1'b0, rd_vld_p1};
  assign issue     = (state_q == S_RUN) && ((occ - {1'b0, pop}) < 2'd2) &&
                     (ptr_q < PTR_W'(TOTAL_PIXEL));
  assign last_beat = pop && (beat_q == TOTAL_PIXEL_BIT'(TOTAL_PIXEL-1));

  assign raddr     = (state_q == S_IDLE) ? rd_addr : ptr_q[TOTAL_PIXEL_BIT-1:0];
  assign mem_rdata = mem[raddr];

  always_comb begin
    we    = wr_en;
    waddr = wr_addr;
    wdata = wr_data;
`ifdef FRAME_BUF_CLEAR_EN
    if (state_q == S_CLEAR) begin
      we    = 1'b1;
      waddr = ptr_q[TOTAL_PIXEL_BIT-1:0];
      wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (issue) pix_p1 <= mem_rdata;
    if (push && ((pop && sk_vld_q) || (!pop && hd_vld_q))) sk_data_q <= pix_p1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      beat_q    <= '0;
      col_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
      rd_vld_p1 <= 1'b0;
      hd_vld_q  <= 1'b0;
      hd_data_q <= '0;
      sk_vld_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      rd_vld_p1 <= issue;

      // Output buffer: head drives the stream, skid holds the second entry.
      if (pop) begin
        if (sk_vld_q) begin
          hd_data_q <= sk_data_q;
          sk_vld_q  <= push;
        end else begin
          hd_vld_q <= push;
          if (push) hd_data_q <= pix_p1;
        end
      end else if (push) begin
        if (hd_vld_q) begin
          sk_vld_q <= 1'b1;
        end else begin
          hd_vld_q  <= 1'b1;
          hd_data_q <= pix_p1;
        end
      end

      case (state_q)
        S_IDLE: begin
          rd_data_q <= mem_rdata;
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
            beat_q  <= '0;
            col_q   <= '0;
          end
`ifdef FRAME_BUF_CLEAR_EN
          else if (clr) begin
            state_q <= S_CLEAR;
            busy_q  <= 1'b1;
            ptr_q   <= '0;
          end
`endif
        end
        S_RUN: begin
          if (issue) ptr_q <= ptr_q + PTR_W'(1);
          if (pop) begin
            beat_q <= beat_q + TOTAL_PIXEL_BIT'(1);
            col_q  <= (col_q == COL_W'(W-1)) ? '0 : col_q + COL_W'(1);
          end
          if (last_beat) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
`ifdef FRAME_BUF_CLEAR_EN
        S_CLEAR: begin
          ptr_q <= ptr_q + PTR_W'(1);
          if (ptr_q == PTR_W'(TOTAL_PIXEL-1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign m_valid = hd_vld_q;
  assign m_data  = hd_data_q;
  assign m_eol   = hd_vld_q & (col_q == COL_W'(W-1));
  assign m_last  = hd_vld_q & (beat_q == TOTAL_PIXEL_BIT'(TOTAL_PIXEL-1));

endmodule

// File: doc/frame_buf_stream.md
# frame_buf_stream

Parametrised frame buffer for the histogram pipeline. It keeps the random-access write and read ports of the earlier output RAM and generalises pixel width and frame size. It adds a streaming readout engine that scans the whole frame out over a valid/ready interface, with line and frame markers. It sits after the equalisation stage and feeds the downstream sink or file dumper.

## Interface
- W, 64, frame width in pixels
- H, 64, frame height in pixels
- DATA_W, 8, pixel width in bits
- TOTAL_PIXEL, W*H, frame size
- TOTAL_PIXEL_BIT, $clog2(W*H), address width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write strobe
- wr_addr  in  TOTAL_PIXEL_BIT  write address
- wr_data  in  DATA_W  write data
- rd_addr  in  TOTAL_PIXEL_BIT  random read address
- rd_data  out  DATA_W  random read data, registered
- start  in  1  begin frame readout; sampled only in IDLE
- busy  out  1  readout (or clear) in progress
- done  out  1  one-cycle pulse at frame end
- m_valid  out  1  stream beat valid
- m_ready  in  1  sink accepts beat
- m_data  out  DATA_W  stream pixel
- m_eol  out  1  beat is last pixel of a row (x == W-1)
- m_last  out  1  beat is pixel TOTAL_PIXEL-1

## Operation
- Memory: TOTAL_PIXEL x DATA_W, one write port and one read port. Contents are not reset.
- Write: wr_en=1 writes wr_data to wr_addr at the edge. It is always accepted, including while streaming (except during clear).
- Same-address write and read in the same cycle: read returns old data (read-before-write).
- Random read: in IDLE, rd_data equals mem[rd_addr] one edge after rd_addr is presented. While busy=1, rd_addr is ignored and rd_data holds its last value.
- FSM states:
  - IDLE -> RUN on start=1: busy=1, issue pointer=0, beat counter=0.
  - RUN: reads are issued in ascending address order into a 2-entry output buffer. A read is issued when (buffered + in-flight − pop_this_cycle) < 2 and the issue pointer < TOTAL_PIXEL.
  - RUN -> IDLE on handshake (m_valid & m_ready) of beat TOTAL_PIXEL-1.
- Beat handshake: a beat transfers when m_valid & m_ready. While m_valid=1 and m_ready=0, m_data, m_eol and m_last are held stable. No beat is lost or duplicated.
- Markers are computed from the beat index: m_eol when index % W == W-1; m_last when index == TOTAL_PIXEL-1. On the final beat both are 1.
- start while busy=1 is ignored.
- Reset: all outputs 0 (rd_data, busy, done, m_valid, m_data, m_eol, m_last). FSM goes to IDLE; pointers and buffer are cleared. Reset mid-stream aborts the frame; m_valid drops asynchronously.

## Timing
- Random read latency: 1 cycle.
- Stream latency: start sampled at edge N; first m_valid=1 after edge N+2.
- Throughput: with m_ready held 1, one beat per cycle. A full frame finishes in TOTAL_PIXEL consecutive cycles after the first valid.
- done: high for exactly one cycle after the edge at which the last beat handshakes. busy falls at that same edge.
- A new start is accepted the cycle done is high (the FSM is already IDLE).

## Configuration
- FRAME_BUF_CLEAR_EN defined:
  - Adds input port clr (1 bit) and state CLEAR.
  - IDLE -> CLEAR on clr=1. The block writes 0 to addresses 0..TOTAL_PIXEL-1, one per cycle, with busy=1 for TOTAL_PIXEL cycles. It then returns to IDLE with no done pulse.
  - During CLEAR, wr_en and start are ignored.
  - If clr and start are both high in IDLE, start wins.
- Not defined: no clr port and no CLEAR state. Memory is cleared only by writes.

## Test plan
- Ramp write/read: write mem[i]=i%256 for i=0..4095 via the random port, then read each address. rd_data == i%256 one cycle after rd_addr=i.
- Full-rate stream: after the ramp, pulse start with m_ready=1. First m_valid 2 cycles after start; 4096 consecutive beats with m_data = idx%256; m_eol at idx 63, 127, …, 4095; m_last only at 4095; one-cycle done.
- Backpressure: random m_ready (~50%) over a full frame. Exactly 4096 beats in order, no gaps or duplicates in the data sequence; outputs stable on every stalled cycle.
- Boundary: start while busy → ignored, frame count stays 1. Write to mem[10]=0xAA while streaming, before beat 10 is issued → beat 10 carries 0xAA.
- Reset mid-stream: assert rst after beat 100. m_valid/busy drop to 0 immediately; a new start streams from index 0 with m_data=0x00.
- With FRAME_BUF_CLEAR_EN: pulse clr after the ramp. busy stays high 4096 cycles; a subsequent stream returns 4096 zeros.
